// File: rtl/ifetch_rv32i.sv
// RV32I instruction fetch stage: one outstanding instruction-memory request,
// a single presentation slot toward decode, and redirect/flush handling.
module ifetch_rv32i #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  input  logic        id_ready
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_FULL
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   req_pc;
  logic              aligned;

  // Request and PC handshake are combinational so the PC register can load
  // next_pc on the same edge the memory accepts the request.
  assign aligned    = (pc[1:0] == 2'b00);
  assign imem_addr  = pc;
  assign imem_req   = !reset && (state == S_REQ) && !flush && aligned;
  assign pc_advance = imem_req && imem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      if_valid    <= 1'b0;
      if_misalign <= 1'b0;
      if_pc       <= '0;
      if_instr    <= NOP_INSTR;
      req_pc      <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (!flush) begin
            if (!aligned) begin
              if_valid    <= 1'b1;
              if_misalign <= 1'b1;
              if_pc       <= pc;
              if_instr    <= NOP_INSTR;
              state       <= S_FULL;
            end else if (imem_gnt) begin
              req_pc <= pc;
              state  <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (flush) begin
            // A response arriving with the flush is simply dropped.
            state <= imem_rvalid ? S_REQ : S_DROP;
          end else if (imem_rvalid) begin
            if_valid    <= 1'b1;
            if_misalign <= 1'b0;
            if_pc       <= req_pc;
            if_instr    <= imem_rdata;
            state       <= S_FULL;
          end
        end

        S_DROP: begin
          if (imem_rvalid) state <= S_REQ;
        end

        S_FULL: begin
          if (flush || id_ready) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_rv32i.sv
// Directed bench for ifetch_rv32i: a transaction-level fetch model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_ifetch_rv32i;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;
  logic        id_ready;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  ifetch_rv32i #(.NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_advance (pc_advance),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_misalign(if_misalign),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a presented slot, an outstanding-request flag
  // and a "response is stale" flag; no state machine encoding.
  bit          m_startup = 1'b1;
  bit          m_pending = 1'b0;
  bit          m_stale   = 1'b0;
  bit          m_valid   = 1'b0;
  bit          m_mis     = 1'b0;
  logic [31:0] m_pc      = '0;
  logic [31:0] m_instr   = NOP;
  logic [31:0] m_req_pc  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_startup = 1'b1; m_pending = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_mis = 1'b0; m_pc = '0; m_instr = NOP; m_req_pc = '0;
    end else if (m_startup) begin
      m_startup = 1'b0;
    end else if (m_valid) begin
      if (flush || id_ready) m_valid = 1'b0;
    end else if (m_pending) begin
      if (imem_rvalid) begin
        if (!(m_stale || flush)) begin
          m_valid = 1'b1; m_mis = 1'b0; m_pc = m_req_pc; m_instr = imem_rdata;
        end
        m_pending = 1'b0;
        m_stale   = 1'b0;
      end else if (flush) begin
        m_stale = 1'b1;
      end
    end else if (!flush) begin
      if (pc % 4 != 0) begin
        m_valid = 1'b1; m_mis = 1'b1; m_pc = pc; m_instr = NOP;
      end else if (imem_gnt) begin
        m_pending = 1'b1;
        m_req_pc  = pc;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic exp_req;
      exp_req = !reset && !m_startup && !m_pending && !m_valid && !flush && (pc % 4 == 0);
      chk("model imem_req", 32'(imem_req), 32'(exp_req));
      chk("model pc_advance", 32'(pc_advance), 32'(exp_req && imem_gnt));
      chk("model imem_addr", imem_addr, pc);
      chk("model if_valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model if_pc", if_pc, m_pc);
        chk("model if_instr", if_instr, m_instr);
        chk("model if_misalign", 32'(if_misalign), 32'(m_mis));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    cyc(); cyc();

    // cycle 1: first cycle after reset release
    reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1; check_en = 1'b1;
    @(negedge clk);
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst if_misalign", 32'(if_misalign), 32'd0);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_instr", if_instr, NOP);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    cyc(); // cycle 2
    @(negedge clk);
    chk("c2 imem_req", 32'(imem_req), 32'd1);
    chk("c2 pc_advance", 32'(pc_advance), 32'd1);
    cyc(); pc = 32'd4; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500093; // cycle 3
    cyc(); imem_rvalid = 1'b0; // cycle 4
    @(negedge clk);
    chk("c4 if_valid", 32'(if_valid), 32'd1);
    chk("c4 if_pc", if_pc, 32'd0);
    chk("c4 if_instr", if_instr, 32'h00500093);
    cyc(); // cycle 5
    @(negedge clk);
    chk("c5 imem_req", 32'(imem_req), 32'd1);
    chk("c5 imem_addr", imem_addr, 32'd4);

    // flush in REQ, then grant stall at 0x100
    cyc(); flush = 1'b1; pc = 32'h100;
    @(negedge clk);
    chk("flush req suppressed", 32'(imem_req), 32'd0);
    cyc(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5A5A5A5A;
    cyc(); imem_rvalid = 1'b0;
    cyc();
    @(negedge clk);
    chk("stall imem_req", 32'(imem_req), 32'd1);
    chk("stall imem_addr", imem_addr, 32'h100);
    chk("stall pc_advance", 32'(pc_advance), 32'd0);
    cyc(); imem_gnt = 1'b1;
    @(negedge clk);
    chk("grant pulse", 32'(pc_advance), 32'd1);
    cyc(); imem_gnt = 1'b0; pc = 32'h104;
    @(negedge clk);
    chk("wait no req", 32'(imem_req), 32'd0);

    // hold in FULL for 5 cycles with a stray rvalid
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h11111111; id_ready = 1'b0;
    cyc(); imem_rvalid = 1'b0;
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h99999999;
    cyc(); imem_rvalid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("hold if_pc", if_pc, 32'h100);
    chk("hold if_instr", if_instr, 32'h11111111);
    chk("hold pc_advance", 32'(pc_advance), 32'd0);
    cyc(); id_ready = 1'b1;

    // flush in WAIT -> DROP, stale DEADBEEF discarded
    cyc(); imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0; flush = 1'b1; pc = 32'hC000;
    cyc();
    @(negedge clk);
    chk("drop no req", 32'(imem_req), 32'd0);
    cyc(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    cyc(); imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("drop no present", 32'(if_valid), 32'd0);
    chk("redirect addr", imem_addr, 32'hC000);
    chk("redirect req", 32'(imem_req), 32'd1);
    cyc(); imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h33333333; pc = 32'hC100;

    // misaligned pc
    cyc(); flush = 1'b0; imem_rvalid = 1'b0; pc = 32'h1002; imem_gnt = 1'b1;
    @(negedge clk);
    chk("flush+rvalid dropped", 32'(if_valid), 32'd0);
    chk("misalign no req", 32'(imem_req), 32'd0);
    cyc(); flush = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk("misalign if_valid", 32'(if_valid), 32'd1);
    chk("misalign flag", 32'(if_misalign), 32'd1);
    chk("misalign if_pc", if_pc, 32'h1002);
    chk("misalign if_instr", if_instr, 32'h00000013);
    cyc(); flush = 1'b0; pc = 32'h2000; imem_gnt = 1'b1;
    @(negedge clk);
    chk("flush full clears", 32'(if_valid), 32'd0);

    // reset in WAIT with a late rvalid during reset
    cyc(); imem_gnt = 1'b0; reset = 1'b1;
    cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rst wait if_valid", 32'(if_valid), 32'd0);
    chk("rst wait imem_req", 32'(imem_req), 32'd0);
    cyc(); reset = 1'b0; imem_rvalid = 1'b0;
    cyc(); imem_gnt = 1'b1;
    @(negedge clk);
    chk("post rst req addr", imem_addr, 32'h2000);
    chk("post rst req", 32'(imem_req), 32'd1);
    cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h22222222; id_ready = 1'b0;
    cyc(); imem_rvalid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("full instr", if_instr, 32'h22222222);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("rst full if_valid", 32'(if_valid), 32'd0);
    chk("rst full if_instr", if_instr, NOP);
    chk("rst full imem_req", 32'(imem_req), 32'd0);

    // back-to-back zero-wait fetches: one per 3 cycles
    for (int k = 0; k < 4; k++) begin
      cyc(); pc = 32'h3000 + 32'(4 * k); imem_gnt = 1'b1; id_ready = 1'b0;
      @(negedge clk);
      chk("b2b pc_advance", 32'(pc_advance), 32'd1);
      cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA0000000 + 32'(k);
      cyc(); imem_rvalid = 1'b0; id_ready = 1'b1;
      @(negedge clk);
      chk("b2b if_pc", if_pc, 32'h3000 + 32'(4 * k));
      chk("b2b if_instr", if_instr, 32'hA0000000 + 32'(k));
    end
    cyc(); cyc();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_rv32i.md
IFETCH_RV32I -- requirements
Module: ifetch_rv32i

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction word driven on if_instr at reset and on misaligned-fetch faults.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 pc  input  32  SHALL carry the current PC from the PC register.
REQ-005 pc_advance  output  1  SHALL be a one-cycle pulse telling the PC register to load next_pc on the next edge.
REQ-006 flush  input  1  SHALL be the redirect request: the PC is being overwritten and all in-flight work is discarded.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  output  32  SHALL be the request address.
REQ-009 imem_gnt  input  1  SHALL be the memory acceptance; a request is accepted only when imem_req and imem_gnt are both 1 in the same cycle.
REQ-010 imem_rvalid  input  1  SHALL be the read-data valid signal.
REQ-011 imem_rdata  input  32  SHALL be the read data.
REQ-012 if_valid  output  1  SHALL indicate that a fetched instruction is presented to decode.
REQ-013 if_pc  output  32  SHALL be the PC of the presented instruction.
REQ-014 if_instr  output  32  SHALL be the presented instruction word.
REQ-015 if_misalign  output  1  SHALL flag a misaligned-fetch fault for the presented entry.
REQ-016 id_ready  input  1  SHALL be the decode acceptance; the entry is consumed when if_valid and id_ready are both 1.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP and FULL; at most one memory request SHALL be outstanding.
REQ-018 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-019 imem_addr SHALL equal pc at all times; imem_req SHALL be 1 only when state is REQ, flush is 0 and pc[1:0] is 2'b00.
REQ-020 In REQ, on acceptance: pc_advance=1 that cycle; req_pc<=pc; next state WAIT.
REQ-021 In REQ, with pc[1:0]!=0 and flush=0:
- no request, pc_advance=0;
- load if_valid=1, if_misalign=1, if_pc=pc, if_instr=NOP_INSTR;
- next state FULL.
REQ-022 In WAIT, on imem_rvalid=1: load if_valid=1, if_instr=imem_rdata, if_pc=req_pc, if_misalign=0; next state FULL.
REQ-023 In FULL, outputs SHALL hold stable until id_ready=1; on consumption, if_valid<=0 and next state REQ.
REQ-024 pc_advance SHALL be 0 in every state other than REQ and whenever flush=1.
REQ-025 flush in REQ SHALL suppress imem_req and pc_advance, and the block SHALL stay in REQ.
REQ-026 flush in WAIT SHALL discard the response:
- if imem_rvalid=1 in the same cycle, go to REQ;
- otherwise go to DROP.
REQ-027 DROP SHALL ignore flush, discard imem_rdata, and go to REQ on imem_rvalid=1.
REQ-028 flush in FULL SHALL clear if_valid and go to REQ, even if id_ready=1 in the same cycle (flush has priority).
REQ-029 imem_rvalid outside WAIT and DROP SHALL be ignored.
REQ-030 Back-to-back throughput with zero-wait memory SHALL be one instruction per 3 cycles: REQ, WAIT, FULL.

Reset
REQ-031 While reset=1 at an edge: state<=IDLE, if_valid=0, if_misalign=0, if_pc=0, if_instr=NOP_INSTR, req_pc=0.
REQ-032 During reset, imem_req=0 and pc_advance=0.
REQ-033 Reset SHALL abandon any in-flight request without entering DROP; the memory is reset on the same reset.
REQ-034 First request SHALL be issued in the second cycle after the reset-release edge.

Verification
REQ-035 Reset release, pc=0, gnt=1, rvalid=1 one cycle after gnt with rdata=32'h00500093, id_ready=1 ->
- imem_req and pc_advance high in cycle 2;
- if_valid=1, if_pc=0, if_instr=32'h00500093 in cycle 4;
- next request at pc=4 in cycle 5.
REQ-036 id_ready=0 for 5 cycles while FULL -> if_valid, if_pc and if_instr stable; no imem_req; no pc_advance.
REQ-037 gnt=0 for 3 cycles with pc=0x100 -> imem_req held high with imem_addr=0x100, pc_advance=0 until gnt=1, then exactly one pulse.
REQ-038 flush in WAIT, then rvalid two cycles later with rdata=32'hDEADBEEF ->
- DROP entered; DEADBEEF never presented;
- new request issued at the redirected pc=0xC000.
REQ-039 pc=0x1002 in REQ -> no imem_req; if_valid=1, if_misalign=1, if_pc=0x1002, if_instr=32'h00000013.
REQ-040 reset=1 asserted in WAIT and in FULL -> next cycle if_valid=0, imem_req=0; a late rvalid during reset is ignored.
